// File: rtl/online_seq_pkg.sv
// Shared types for the online sequencer: FSM states, signed-digit codes, digit normalisation.
package online_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   localparam logic [1:0] DIG_POS  = 2'b10;
   localparam logic [1:0] DIG_NEG  = 2'b01;
   localparam logic [1:0] DIG_ZERO = 2'b00;

   // {p,n}=11 is a redundant encoding of zero; the datapath only accepts 00
   function automatic logic [1:0] norm_digit(input logic [1:0] d);
      return (d == 2'b11) ? DIG_ZERO : d;
   endfunction

endpackage

// File: rtl/online_digit_shreg.sv
// Parallel-load, MSD-first shift register of N two-bit digits; load wins over shift.
// Shifting moves digits towards the MSD end and inserts shift_in at the LSD end.
module online_digit_shreg
   import online_seq_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [2*N-1:0] load_data,
   input  logic           shift,
   input  logic [1:0]     shift_in,
   output logic [1:0]     msd,
   output logic [2*N-1:0] word
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word <= '0;
      end else if (load) begin
         word <= load_data;
      end else if (shift) begin
         word <= {word[2*N-3:0], shift_in};
      end
   end

   assign msd = word[2*N-1 -: 2];

endmodule

// File: rtl/online_seq_ctrl.sv
// Online sequencer: feeds a word MSD-first then DELTA zeros, collects dp_out; result STAGE+DELTA+1 cycles after accept.
// in_ready only in IDLE; DONE holds the result until out_ready. ONLINE_SEQ_OVF_EN adds integer-part overflow flag.
module online_seq_ctrl
   import online_seq_pkg::*;
#(
   parameter int STAGE = 4,
   parameter int DELTA = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*STAGE-1:0] in_data,
   output logic               dp_init,
   output logic               dp_en,
   output logic [1:0]         dp_digit,
   input  logic [1:0]         dp_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*STAGE-1:0] out_data,
   output logic               out_ovf
);

   localparam int CW = $clog2(STAGE + DELTA + 1);
   localparam logic [CW-1:0] K_FEED_LAST  = CW'(STAGE - 1);
   localparam logic [CW-1:0] K_FLUSH_LAST = CW'(STAGE + DELTA - 1);
   localparam logic [CW-1:0] K_DELTA      = CW'(DELTA);

   seq_state_t         state;
   logic [CW-1:0]      k;
   logic               accept;
   logic               busy;
   logic               capture;
   logic [2*STAGE-1:0] feed_load;
   logic [2*STAGE-1:0] feed_word_unused;
   logic [1:0]         collect_msd_unused;

   assign in_ready = (state == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign dp_init  = accept;
   assign busy     = (state == ST_FEED) || (state == ST_FLUSH);
   // dp_out only carries fractional result digits once the online delay has elapsed
   assign capture  = busy && (k >= K_DELTA);

   always_comb begin
      feed_load = '0;
      for (int i = 0; i < STAGE; i++) begin
         feed_load[2*i +: 2] = norm_digit(in_data[2*i +: 2]);
      end
   end

   // Zero fill means the feed register reads 00 once all digits have left,
   // so dp_digit needs no extra gating in FLUSH/DONE/IDLE.
   online_digit_shreg #(.N(STAGE)) u_feed (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .load_data (feed_load),
      .shift     (state == ST_FEED),
      .shift_in  (DIG_ZERO),
      .msd       (dp_digit),
      .word      (feed_word_unused)
   );

   online_digit_shreg #(.N(STAGE)) u_collect (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .load_data ('0),
      .shift     (capture),
      .shift_in  (dp_out),
      .msd       (collect_msd_unused),
      .word      (out_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         k         <= '0;
         dp_en     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state <= ST_FEED;
                  k     <= '0;
                  dp_en <= 1'b1;
               end
            end
            ST_FEED: begin
               k <= k + 1'b1;
               if (k == K_FEED_LAST) begin
                  state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (k == K_FLUSH_LAST) begin
                  state     <= ST_DONE;
                  dp_en     <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               dp_en     <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ONLINE_SEQ_OVF_EN
   // A nonzero digit before the online delay has elapsed is an integer-part digit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_ovf <= 1'b0;
      end else if (accept) begin
         out_ovf <= 1'b0;
      end else if (busy && (k < K_DELTA) && (dp_out != DIG_ZERO)) begin
         out_ovf <= 1'b1;
      end
   end
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_online_seq_ctrl.sv
// Directed bench for online_seq_ctrl (STAGE=4, DELTA=2) with a DELTA-cycle delay datapath model.
module tb_online_seq_ctrl;

   localparam int STAGE = 4;
   localparam int DELTA = 2;
`ifdef ONLINE_SEQ_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       dp_init;
   logic       dp_en;
   logic [1:0] dp_digit;
   logic [1:0] dp_out;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_ovf;

   logic [3:0] pipe = '0;
   logic       force_ovf = 1'b0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dp_init) pipe <= '0;
      else         pipe <= {pipe[1:0], dp_digit};
   end
   assign dp_out = force_ovf ? 2'b10 : pipe[3:2];

   online_seq_ctrl #(.STAGE(STAGE), .DELTA(DELTA)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .dp_init   (dp_init),
      .dp_en     (dp_en),
      .dp_digit  (dp_digit),
      .dp_out    (dp_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      check("idle_wait", in_ready, 1);
   endtask

   task automatic send_word(input logic [7:0] w, input logic [7:0] exp, input logic exp_ovf,
                            input bit frc, input int stall);
      logic [1:0] ed;
      wait_idle();
      in_data  = w;
      in_valid = 1'b1;
      #1;
      check("acc_init", dp_init, 1);
      check("acc_vld", out_valid, 0);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < STAGE + DELTA; k++) begin
         ed = (k < STAGE) ? exp[2*(STAGE-1-k) +: 2] : 2'b00;
         if (frc && k == 0) force_ovf = 1'b1;
         check("feed_en", dp_en, 1);
         check("feed_dig", dp_digit, ed);
         check("feed_init", dp_init, 0);
         check("feed_rdy", in_ready, 0);
         check("feed_vld", out_valid, 0);
         if (k == 0) check("acc_clr", {out_ovf, out_data}, 9'h000);
         tick();
         force_ovf = 1'b0;
      end
      check("done_vld", out_valid, 1);
      check("done_dat", out_data, exp);
      check("done_ovf", out_ovf, exp_ovf);
      check("done_en", dp_en, 0);
      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_vld", out_valid, 1);
         check("stall_dat", out_data, exp);
         check("stall_rdy", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hs_vld", out_valid, 0);
      check("hs_rdy", in_ready, 1);
      check("hs_ovf_hold", out_ovf, exp_ovf);
   endtask

   initial begin
      int last;
      int n;

      // Reset state
      tick(); tick(); tick();
      check("rst_rdy", in_ready, 1);
      check("rst_vld", out_valid, 0);
      check("rst_en", dp_en, 0);
      check("rst_dig", dp_digit, 0);
      check("rst_dat", out_data, 0);
      check("rst_ovf", out_ovf, 0);
      rst_n = 1'b1;
      tick();

      // 1 basic
      send_word(8'b10_00_01_10, 8'b10_00_01_10, 1'b0, 1'b0, 0);

      // 2 backpressure in DONE
      send_word(8'b01_00_10_10, 8'b01_00_10_10, 1'b0, 1'b0, 5);
      tick();
      check("bp_single_hs", in_ready, 1);

      // 3 reset at FEED k=2
      wait_idle();
      in_data  = 8'b10_00_01_10;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      check("midrst_en", dp_en, 1);
      check("midrst_dig", dp_digit, 2'b01);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_rdy", in_ready, 1);
      check("midrst_vld", out_valid, 0);
      check("midrst_en0", dp_en, 0);
      check("midrst_dig0", dp_digit, 0);
      check("midrst_dat", out_data, 0);
      send_word(8'b01_01_01_01, 8'b01_01_01_01, 1'b0, 1'b0, 0);

      // 4 back-to-back with in_valid held
      wait_idle();
      in_data   = 8'b10_01_00_10;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      last = -1;
      n    = 0;
      #1;
      for (int c = 0; c < 40; c++) begin
         check("b2b_init_busy", dp_init & dp_en, 0);
         if (dp_init) begin
            if (last >= 0) check("b2b_gap", c - last, 8);
            last = c;
            n++;
         end
         tick();
      end
      in_valid = 1'b0;
      check("b2b_count", n, 5);
      check("b2b_done_dat", out_data, 8'b10_01_00_10);
      wait_idle();
      out_ready = 1'b0;

      // 5 overflow, then cleared by the next accept
      send_word(8'b10_10_00_01, 8'b10_10_00_01, OVF_ON, 1'b1, 0);
      send_word(8'b00_01_00_10, 8'b00_01_00_10, 1'b0, 1'b0, 0);

      // 6 code 11 normalised to 00
      send_word(8'b11_10_11_01, 8'b00_10_00_01, 1'b0, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
